sync_fifo_ctl: RTL

- Parametrised single-clock FIFO: next generation of the team's FIFO wrapper, for same-domain buffering between datapath stages.
- Adds over the previous generation:
  - selectable show-ahead or normal read mode
  - programmable almost-full / almost-empty thresholds
  - fill-level count
  - synchronous flush
  - sticky overflow/underflow error flags
- Storage is an inferred simple-dual-port RAM; control logic is native RTL with no vendor megafunction.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/sync_fifo_ctl_if.sv | 30 +++
 rtl/fifo_sdp_ram.sv | 29 ++
 rtl/sync_fifo_ctl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

  // Read-side presentation mode of the FIFO output.
  typedef enum logic {
    FIFO_NORMAL    = 1'b0,
    FIFO_SHOWAHEAD = 1'b1
  } fifo_mode_e;

  // Default geometry and thresholds.
  localparam int DEF_ADDR_LEN      = 4;
  localparam int DEF_AFULL_MARGIN  = 2;
  localparam int DEF_AEMPTY_THRESH = 2;

  // Pointers carry one extra wrap bit beyond the RAM address.
  function automatic int ptr_width(input int addr_len);
    return addr_len + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Bus bundle between a FIFO user (master) and the FIFO itself (slave).
interface sync_fifo_ctl_if #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_LEN = 4
);
  logic                flush;
  logic [DATA_LEN-1:0] data_in;
  logic                wrt_en;
  logic                wrt_full;
  logic                wrt_almost_full;
  logic [DATA_LEN-1:0] data_out;
  logic                rd_en;
  logic                rd_empty;
  logic                rd_almost_empty;
  logic [ADDR_LEN:0]   usedw;
  logic                overflow;
  logic                underflow;

  modport master (
    output flush, data_in, wrt_en, rd_en,
    input  wrt_full, wrt_almost_full, data_out, rd_empty, rd_almost_empty,
           usedw, overflow, underflow
  );

  modport slave (
    input  flush, data_in, wrt_en, rd_en,
    output wrt_full, wrt_almost_full, data_out, rd_empty, rd_almost_empty,
           usedw, overflow, underflow
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fifo_sdp_ram #(
  parameter int DATA_LEN   = 16,
  parameter int ADDR_LEN   = 4,
  parameter int FIFO_DEPTH = 1 << ADDR_LEN
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [DATA_LEN-1:0] rdata_q;

  // Write port and registered read port share the clock.
  // NOTE: the array and its read register have no reset, so the
  // storage maps onto block RAM; the FIFO masks its output after reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: wrap-bit pointers, registered status,
// sticky error flags, synchronous flush, normal or show-ahead output.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DATA_LEN      = 16,
  parameter int ADDR_LEN      = DEF_ADDR_LEN,
  parameter int FIFO_DEPTH    = 1 << ADDR_LEN,
  parameter int SHOWAHEAD     = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input logic            clk,
  input logic            reset_n,
  sync_fifo_ctl_if.slave bus
);

  localparam int            PW         = ptr_width(ADDR_LEN);
  localparam fifo_mode_e    MODE       = (SHOWAHEAD != 0) ? FIFO_SHOWAHEAD : FIFO_NORMAL;
  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  if (ADDR_LEN < 2) begin : g_bad_addr_len
    $fatal(1, "sync_fifo_ctl: ADDR_LEN must be >= 2");
  end
  if (FIFO_DEPTH != (1 << ADDR_LEN)) begin : g_bad_depth
    $fatal(1, "sync_fifo_ctl: FIFO_DEPTH must equal 1 << ADDR_LEN");
  end

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       usedw_q, usedw_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                sel_byp_q, sel_byp_d;
  logic [DATA_LEN-1:0] byp_q, byp_d;

  logic                wr_acc, rd_acc;
  logic                ram_re;
  logic [ADDR_LEN-1:0] ram_raddr;
  logic [DATA_LEN-1:0] ram_rdata;

  // Request acceptance, next pointers, status and sticky error flags.
  // NOTE: every variable gets a default at the top of the block so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_acc   = bus.wrt_en & ~full_q  & ~bus.flush;
    rd_acc   = bus.rd_en  & ~empty_q & ~bus.flush;
    wr_ptr_d = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d = rd_ptr_q + PW'(rd_acc);
    ovf_d    = ovf_q | (bus.wrt_en & full_q);
    udf_d    = udf_q | (bus.rd_en & empty_q);
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
    usedw_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[ADDR_LEN-1:0] == rd_ptr_d[ADDR_LEN-1:0]) &&
               (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]);
    afull_d  = (usedw_d >= AFULL_LVL);
    aempty_d = (usedw_d <= AEMPTY_LVL);
  end

  // Output selection: registered RAM read, or a bypass register that
  // catches a word written straight into the head slot (show-ahead only).
  // The bypass register also supplies the zero output after reset.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = rd_ptr_q[ADDR_LEN-1:0];
    byp_d     = byp_q;
    sel_byp_d = sel_byp_q;
    if (!bus.flush) begin
      if (MODE == FIFO_SHOWAHEAD) begin
        if (!empty_d) begin
          if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            byp_d     = bus.data_in;
            sel_byp_d = 1'b1;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = rd_ptr_d[ADDR_LEN-1:0];
            sel_byp_d = 1'b0;
          end
        end
      end else if (rd_acc) begin
        ram_re    = 1'b1;
        sel_byp_d = 1'b0;
      end
    end
  end

  // Control state register with asynchronous reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      sel_byp_q <= 1'b1;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      sel_byp_q <= sel_byp_d;
      byp_q     <= byp_d;
    end
  end

  fifo_sdp_ram #(
    .DATA_LEN   (DATA_LEN),
    .ADDR_LEN   (ADDR_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_LEN-1:0]),
    .wdata (bus.data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.data_out        = sel_byp_q ? byp_q : ram_rdata;
  assign bus.wrt_full        = full_q;
  assign bus.wrt_almost_full = afull_q;
  assign bus.rd_empty        = empty_q;
  assign bus.rd_almost_empty = aempty_q;
  assign bus.usedw           = usedw_q;
  assign bus.overflow        = ovf_q;
  assign bus.underflow       = udf_q;

endmodule
